// File: rtl/score_bcd_keeper_pkg.sv
// ============================================================================
// Module      : score_pkg
// Description : Shared constants, FSM states and BCD digit type for the
//               score keeper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package score_pkg;

    localparam int PTS_W      = 8;
    localparam int SCORE_W    = 14;
    localparam int MAX_SCORE  = 9999;
    localparam int CONV_ITERS = 14;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CONV  = 2'd2
    } state_t;

    // Digit 0 = ones ... digit 3 = thousands
    typedef logic [BCD_DIGITS-1:0][3:0] bcd4_t;

endpackage

`default_nettype wire

// File: rtl/score_bcd_keeper_if.sv
// ============================================================================
// Module      : score_bcd_keeper_if
// Description : Points-add handshake, score status and display digit bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface score_bcd_keeper_if;

    logic                             add_valid;
    logic [score_pkg::PTS_W-1:0]      add_pts;
    logic                             add_ready;
    logic                             clear_score;
    logic [score_pkg::SCORE_W-1:0]    score_bin;
    logic                             saturated;
    logic                             busy;
    logic [3:0]                       disp_ones;
    logic [3:0]                       disp_tens;
    logic [3:0]                       disp_hundreds;
    logic [3:0]                       disp_thousands;

    modport master (
        output add_valid, add_pts, clear_score,
        input  add_ready, score_bin, saturated, busy,
               disp_ones, disp_tens, disp_hundreds, disp_thousands
    );

    modport slave (
        input  add_valid, add_pts, clear_score,
        output add_ready, score_bin, saturated, busy,
               disp_ones, disp_tens, disp_hundreds, disp_thousands
    );

endinterface

`default_nettype wire

// File: rtl/score_bcd_keeper_bcd_dd_seq.sv
// ============================================================================
// Module      : bcd_dd_seq
// Description : Sequential double-dabble converter, one shift per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_dd_seq
    import score_pkg::*;
#(
    parameter int BIN_W = SCORE_W,
    parameter int ITERS = BIN_W
) (
    input  wire logic             iVGA_CLK,
    input  wire logic             iRST_n,
    input  wire logic             start,
    input  wire logic             abort,
    input  wire logic [BIN_W-1:0] bin_in,
    output logic                  done,
    output bcd4_t                 bcd_out
);

    localparam int CNT_W  = $clog2(ITERS + 1);
    localparam int SHIFT_W = BCD_W + BIN_W;

    logic [SHIFT_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_run;
    logic [SHIFT_W-1:0] w_adj;
    logic [SHIFT_W-1:0] w_next;

    always_comb begin
        w_adj = r_shift;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (r_shift[BIN_W + 4*d +: 4] >= 4'd5) begin
                w_adj[BIN_W + 4*d +: 4] = r_shift[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
        w_next = {w_adj[SHIFT_W-2:0], 1'b0};
    end

    // done and bcd_out describe the shift happening this cycle, so the
    // caller can capture the result on the same edge as the final shift.
    assign done    = r_run && (r_cnt == CNT_W'(ITERS - 1));
    assign bcd_out = bcd4_t'(w_next[BIN_W +: BCD_W]);

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
        end else if (abort) begin
            r_cnt   <= '0;
            r_run   <= 1'b0;
        end else if (start) begin
            r_shift <= {{BCD_W{1'b0}}, bin_in};
            r_cnt   <= '0;
            r_run   <= 1'b1;
        end else if (r_run) begin
            r_shift <= w_next;
            if (done) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/score_bcd_keeper.sv
// ============================================================================
// Module      : score_bcd_keeper
// Description : Saturating score accumulator with frame-synchronous BCD
//               digit outputs for the score overlay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_bcd_keeper
    import score_pkg::*;
(
    input  wire logic           iVGA_CLK,
    input  wire logic           iRST_n,
    input  wire logic           iVS,
    score_bcd_keeper_if.slave   bus
);

    state_t               r_state;
    state_t               w_state_next;
    logic [PTS_W-1:0]     r_pts;
    logic [SCORE_W-1:0]   r_score;
    logic                 r_sat;
    bcd4_t                r_pending;
    logic                 r_pending_valid;
    bcd4_t                r_disp;
    logic                 r_vs_d;

    logic [SCORE_W:0]     w_sum;
    logic                 w_over;
    logic [SCORE_W-1:0]   w_new_score;
    logic                 w_add_fire;
    logic                 w_frame_edge;
    logic                 w_start;
    logic                 w_conv_done;
    bcd4_t                w_conv_bcd;

    assign bus.add_ready = (r_state == IDLE) && !bus.clear_score;
    assign w_add_fire    = bus.add_valid && bus.add_ready;
    assign w_frame_edge  = r_vs_d && !iVS;

    assign w_sum       = {1'b0, r_score} + (SCORE_W + 1)'(r_pts);
    assign w_over      = w_sum > (SCORE_W + 1)'(MAX_SCORE);
    assign w_new_score = w_over ? SCORE_W'(MAX_SCORE) : w_sum[SCORE_W-1:0];

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            IDLE:  if (w_add_fire) w_state_next = ACCUM;
            ACCUM: begin
                w_start      = 1'b1;
                w_state_next = CONV;
            end
            CONV:  if (w_conv_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (bus.clear_score) begin
            w_state_next = IDLE;
            w_start      = 1'b0;
        end
    end

    // Later assignments win: clear overrides everything, and a freshly set
    // pending_valid survives a coincident frame edge so it shows next frame.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_pts           <= '0;
            r_score         <= '0;
            r_sat           <= 1'b0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_disp          <= '0;
            r_vs_d          <= 1'b1;
        end else begin
            r_vs_d <= iVS;
            if (w_add_fire) begin
                r_pts <= bus.add_pts;
            end
            if (w_frame_edge && r_pending_valid) begin
                r_disp          <= r_pending;
                r_pending_valid <= 1'b0;
            end
            if (bus.clear_score) begin
                r_score         <= '0;
                r_sat           <= 1'b0;
                r_pending       <= '0;
                r_pending_valid <= 1'b1;
            end else begin
                if (r_state == ACCUM) begin
                    r_score <= w_new_score;
                    if (w_over) r_sat <= 1'b1;
                end
                if ((r_state == CONV) && w_conv_done) begin
                    r_pending       <= w_conv_bcd;
                    r_pending_valid <= 1'b1;
                end
            end
        end
    end

    bcd_dd_seq #(
        .BIN_W (SCORE_W),
        .ITERS (CONV_ITERS)
    ) u_dd (
        .iVGA_CLK (iVGA_CLK),
        .iRST_n   (iRST_n),
        .start    (w_start),
        .abort    (bus.clear_score),
        .bin_in   (w_new_score),
        .done     (w_conv_done),
        .bcd_out  (w_conv_bcd)
    );

    assign bus.score_bin      = r_score;
    assign bus.saturated      = r_sat;
    assign bus.busy           = (r_state != IDLE);
    assign bus.disp_ones      = r_disp[0];
    assign bus.disp_tens      = r_disp[1];
    assign bus.disp_hundreds  = r_disp[2];
    assign bus.disp_thousands = r_disp[3];

endmodule

`default_nettype wire
